// File: rtl/mem_pager.sv
// Spectrum memory banking unit: captures the 0x7FFD/0x1FFD paging ports and
// maps each CPU address onto a ROM/RAM bank plus 14-bit offset.
module mem_pager #(
    parameter int MODE_128      = 1,
    parameter int ENABLE_PLUS2A = 0,
    parameter int RAM_BANK_BITS = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [15:0]              cpu_addr,
    input  logic [7:0]               cpu_dout,
    input  logic                     n_iorq,
    input  logic                     n_mreq,
    input  logic                     n_wr,
    input  logic                     n_m1,
    output logic                     is_rom,
    output logic [1:0]               rom_bank,
    output logic [RAM_BANK_BITS-1:0] ram_bank,
    output logic [13:0]              offset,
    output logic                     ram_we,
    output logic                     screen_bank7,
    output logic                     locked,
    output logic [7:0]               reg_7ffd,
    output logic [7:0]               reg_1ffd
);

    localparam bit PAGED = (MODE_128 != 0);
    localparam bit P2A   = (ENABLE_PLUS2A != 0);

    logic       iow;
    logic       iow_d;
    logic       wr_evt;
    logic       hit_7ffd;
    logic       hit_1ffd;
    logic [7:0] r7;
    logic [7:0] r1;
    logic       lock_q;

    assign iow    = ~n_iorq & ~n_wr & n_m1;
    assign wr_evt = iow & ~iow_d;

    assign hit_7ffd = ~cpu_addr[15] & ~cpu_addr[1];
    assign hit_1ffd = P2A && (cpu_addr[15:12] == 4'b0001) && ~cpu_addr[1];

    // One update per OUT: only the rising edge of the strobe counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            iow_d  <= 1'b0;
            r7     <= 8'h00;
            r1     <= 8'h00;
            lock_q <= 1'b0;
        end else begin
            iow_d <= iow;
            if (PAGED && wr_evt && !lock_q) begin
                if (hit_1ffd) begin
                    r1 <= cpu_dout;
                end else if (hit_7ffd) begin
                    r7 <= cpu_dout;
                    if (cpu_dout[5]) begin
                        lock_q <= 1'b1;
                    end
                end
            end
        end
    end

    logic       special;
    logic [1:0] seg;
    logic [7:0] top_bank;
    logic [7:0] bank;

    assign special = P2A && r1[0];
    assign seg     = cpu_addr[15:14];

    // Segment 3 bank with the extension bits trimmed to the configured width.
    always_comb begin
        top_bank = {3'b000, r7[7], r7[6], r7[2:0]};
        if (RAM_BANK_BITS < 5) begin
            top_bank[4] = 1'b0;
        end
        if (RAM_BANK_BITS < 4) begin
            top_bank[3] = 1'b0;
        end
    end

    always_comb begin
        is_rom   = 1'b0;
        rom_bank = 2'b00;
        bank     = 8'd0;
        if (!PAGED) begin
            unique case (seg)
                2'd0: is_rom = 1'b1;
                2'd1: bank = 8'd5;
                2'd2: bank = 8'd2;
                default: bank = 8'd0;
            endcase
        end else if (special) begin
            unique case (r1[2:1])
                2'd0: begin
                    unique case (seg)
                        2'd0: bank = 8'd0;
                        2'd1: bank = 8'd1;
                        2'd2: bank = 8'd2;
                        default: bank = 8'd3;
                    endcase
                end
                2'd1: begin
                    unique case (seg)
                        2'd0: bank = 8'd4;
                        2'd1: bank = 8'd5;
                        2'd2: bank = 8'd6;
                        default: bank = 8'd7;
                    endcase
                end
                2'd2: begin
                    unique case (seg)
                        2'd0: bank = 8'd4;
                        2'd1: bank = 8'd5;
                        2'd2: bank = 8'd6;
                        default: bank = 8'd3;
                    endcase
                end
                default: begin
                    unique case (seg)
                        2'd0: bank = 8'd4;
                        2'd1: bank = 8'd7;
                        2'd2: bank = 8'd6;
                        default: bank = 8'd3;
                    endcase
                end
            endcase
        end else begin
            rom_bank = {P2A ? r1[2] : 1'b0, r7[4]};
            unique case (seg)
                2'd0: is_rom = 1'b1;
                2'd1: bank = 8'd5;
                2'd2: bank = 8'd2;
                default: bank = top_bank;
            endcase
        end
    end

    assign ram_bank     = bank[RAM_BANK_BITS-1:0];
    assign offset       = cpu_addr[13:0];
    assign ram_we       = ~n_mreq & ~n_wr & ~is_rom;
    assign screen_bank7 = PAGED ? r7[3] : 1'b0;
    assign locked       = lock_q;
    assign reg_7ffd     = r7;
    assign reg_1ffd     = P2A ? r1 : 8'h00;

endmodule

// File: tb/tb_mem_pager.sv
// Bench for mem_pager: three configurations share one CPU bus; expected
// values are queued before each probe and compared when outputs settle.
module tb_mem_pager;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        n_iorq, n_mreq, n_wr, n_m1;

    always #5 clk = ~clk;

    // a: 128K, no +2A, 3-bit banks; b: 128K, +2A, 5-bit banks; c: 48K.
    logic       a_rom, b_rom, c_rom;
    logic [1:0] a_rb, b_rb, c_rb;
    logic [2:0] a_bank, c_bank;
    logic [4:0] b_bank;
    logic [13:0] a_off, b_off, c_off;
    logic       a_we, b_we, c_we;
    logic       a_scr, b_scr, c_scr;
    logic       a_lk, b_lk, c_lk;
    logic [7:0] a_r7, b_r7, c_r7;
    logic [7:0] a_r1, b_r1, c_r1;

    mem_pager #(.MODE_128(1), .ENABLE_PLUS2A(0), .RAM_BANK_BITS(3)) dut_a (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .n_iorq(n_iorq), .n_mreq(n_mreq), .n_wr(n_wr), .n_m1(n_m1),
        .is_rom(a_rom), .rom_bank(a_rb), .ram_bank(a_bank), .offset(a_off),
        .ram_we(a_we), .screen_bank7(a_scr), .locked(a_lk),
        .reg_7ffd(a_r7), .reg_1ffd(a_r1)
    );

    mem_pager #(.MODE_128(1), .ENABLE_PLUS2A(1), .RAM_BANK_BITS(5)) dut_b (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .n_iorq(n_iorq), .n_mreq(n_mreq), .n_wr(n_wr), .n_m1(n_m1),
        .is_rom(b_rom), .rom_bank(b_rb), .ram_bank(b_bank), .offset(b_off),
        .ram_we(b_we), .screen_bank7(b_scr), .locked(b_lk),
        .reg_7ffd(b_r7), .reg_1ffd(b_r1)
    );

    mem_pager #(.MODE_128(0), .ENABLE_PLUS2A(0), .RAM_BANK_BITS(3)) dut_c (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .n_iorq(n_iorq), .n_mreq(n_mreq), .n_wr(n_wr), .n_m1(n_m1),
        .is_rom(c_rom), .rom_bank(c_rb), .ram_bank(c_bank), .offset(c_off),
        .ram_we(c_we), .screen_bank7(c_scr), .locked(c_lk),
        .reg_7ffd(c_r7), .reg_1ffd(c_r1)
    );

    localparam int F_ROM = 0, F_RB = 1, F_BANK = 2, F_SCR = 3;
    localparam int F_LK = 4, F_R7 = 5, F_R1 = 6, F_WE = 7, F_OFF = 8;

    typedef struct {
        string      tag;
        int         dut;
        int         fld;
        logic [15:0] exp;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    function automatic logic [15:0] obs(int d, int f);
        logic [15:0] v;
        v = 16'h0;
        case (f)
            F_ROM:  v = {15'h0, d == 0 ? a_rom : d == 1 ? b_rom : c_rom};
            F_RB:   v = {14'h0, d == 0 ? a_rb : d == 1 ? b_rb : c_rb};
            F_BANK: v = d == 0 ? {13'h0, a_bank} :
                        d == 1 ? {11'h0, b_bank} : {13'h0, c_bank};
            F_SCR:  v = {15'h0, d == 0 ? a_scr : d == 1 ? b_scr : c_scr};
            F_LK:   v = {15'h0, d == 0 ? a_lk : d == 1 ? b_lk : c_lk};
            F_R7:   v = {8'h0, d == 0 ? a_r7 : d == 1 ? b_r7 : c_r7};
            F_R1:   v = {8'h0, d == 0 ? a_r1 : d == 1 ? b_r1 : c_r1};
            F_WE:   v = {15'h0, d == 0 ? a_we : d == 1 ? b_we : c_we};
            default: v = {2'b00, d == 0 ? a_off : d == 1 ? b_off : c_off};
        endcase
        return v;
    endfunction

    task automatic check_eq(string tag, logic [15:0] got, logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(string tag, int d, int f, logic [15:0] e);
        exp_t x;
        x.tag = tag;
        x.dut = d;
        x.fld = f;
        x.exp = e;
        sb.push_back(x);
    endtask

    task automatic drain();
        exp_t x;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            check_eq(x.tag, obs(x.dut, x.fld), x.exp);
        end
    endtask

    task automatic probe(logic [15:0] addr);
        @(negedge clk);
        cpu_addr = addr;
        #1;
        drain();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic io_write(logic [15:0] addr, logic [7:0] data, logic m1);
        @(negedge clk);
        cpu_addr = addr;
        cpu_dout = data;
        n_iorq = 1'b0;
        n_wr = 1'b0;
        n_m1 = m1;
        @(negedge clk);
        n_iorq = 1'b1;
        n_wr = 1'b1;
        n_m1 = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        cpu_addr = 16'h0000;
        cpu_dout = 8'h00;
        n_iorq = 1'b1;
        n_mreq = 1'b1;
        n_wr = 1'b1;
        n_m1 = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int d = 0; d < 3; d++) begin
            push("rst_rom", d, F_ROM, 16'd1);
            push("rst_rb", d, F_RB, 16'd0);
            push("rst_scr", d, F_SCR, 16'd0);
            push("rst_lk", d, F_LK, 16'd0);
            push("rst_r7", d, F_R7, 16'h00);
            push("rst_r1", d, F_R1, 16'h00);
        end
        probe(16'h0000);
        for (int d = 0; d < 3; d++) begin
            push("s1_rom", d, F_ROM, 16'd0);
            push("s1_bank", d, F_BANK, 16'd5);
            push("s1_off", d, F_OFF, 16'h1234);
        end
        probe(16'h5234);
        for (int d = 0; d < 3; d++) push("s2_bank", d, F_BANK, 16'd2);
        probe(16'h8000);
        for (int d = 0; d < 3; d++) push("s3_bank", d, F_BANK, 16'd0);
        probe(16'hC000);

        // Strobe held four cycles with data changing after the first edge.
        @(negedge clk);
        cpu_addr = 16'h7FFD;
        cpu_dout = 8'h1B;
        n_iorq = 1'b0;
        n_wr = 1'b0;
        @(negedge clk);
        cpu_dout = 8'h05;
        repeat (3) @(negedge clk);
        n_iorq = 1'b1;
        n_wr = 1'b1;
        push("w1b_r7", 0, F_R7, 16'h1B);
        push("w1b_bank", 0, F_BANK, 16'd3);
        push("w1b_scr", 0, F_SCR, 16'd1);
        push("w1b_b_bank", 1, F_BANK, 16'd3);
        push("w48_r7", 2, F_R7, 16'h00);
        push("w48_bank", 2, F_BANK, 16'd0);
        push("w48_scr", 2, F_SCR, 16'd0);
        probe(16'hC000);
        push("w1b_rb", 0, F_RB, 16'd1);
        push("w48_rb", 2, F_RB, 16'd0);
        probe(16'h0000);

        io_write(16'h7FFD, 8'h24, 1'b1);
        push("lk_set", 0, F_LK, 16'd1);
        push("lk_bank", 0, F_BANK, 16'd4);
        push("lk_b_set", 1, F_LK, 16'd1);
        push("lk_48", 2, F_LK, 16'd0);
        probe(16'hC000);
        io_write(16'h7FFD, 8'h07, 1'b1);
        push("lk_hold", 0, F_LK, 16'd1);
        push("lk_bank2", 0, F_BANK, 16'd4);
        push("lk_r7", 0, F_R7, 16'h24);
        probe(16'hC000);
        do_reset();
        push("lk_clr", 0, F_LK, 16'd0);
        push("lk_clr_r7", 0, F_R7, 16'h00);
        probe(16'hC000);

        // 0x1FFD also decodes as 0x7FFD on the plain 128K part.
        io_write(16'h1FFD, 8'h07, 1'b1);
        push("sp_r1", 1, F_R1, 16'h07);
        push("sp_r7", 1, F_R7, 16'h00);
        push("sp_a_r7", 0, F_R7, 16'h07);
        push("sp_a_r1", 0, F_R1, 16'h00);
        push("sp0_rom", 1, F_ROM, 16'd0);
        push("sp0_bank", 1, F_BANK, 16'd4);
        probe(16'h0000);
        push("sp1_bank", 1, F_BANK, 16'd7);
        probe(16'h4000);
        push("sp2_bank", 1, F_BANK, 16'd6);
        probe(16'h8000);
        push("sp3_bank", 1, F_BANK, 16'd3);
        push("sp3_a_bank", 0, F_BANK, 16'd7);
        probe(16'hC000);
        io_write(16'h1FFD, 8'h04, 1'b1);
        io_write(16'h7FFD, 8'h10, 1'b1);
        push("rom3_rom", 1, F_ROM, 16'd1);
        push("rom3_rb", 1, F_RB, 16'd3);
        push("rom3_a_rb", 0, F_RB, 16'd1);
        probe(16'h0000);

        @(negedge clk);
        n_mreq = 1'b0;
        n_wr = 1'b0;
        push("we_rom", 2, F_WE, 16'd0);
        push("we_rom_a", 0, F_WE, 16'd0);
        probe(16'h1000);
        push("we_ram", 2, F_WE, 16'd1);
        probe(16'h8000);
        @(negedge clk);
        n_mreq = 1'b1;
        n_wr = 1'b1;

        do_reset();
        io_write(16'h7FFD, 8'hC5, 1'b1);
        push("ext_bank", 1, F_BANK, 16'h1D);
        push("ext_a_bank", 0, F_BANK, 16'd5);
        probe(16'hC000);
        io_write(16'h7FFD, 8'h02, 1'b0);
        push("m1_bank", 1, F_BANK, 16'h1D);
        push("m1_r7", 1, F_R7, 16'hC5);
        probe(16'hC000);

        // Reset coincides with a write event.
        @(negedge clk);
        reset = 1'b1;
        cpu_addr = 16'h7FFD;
        cpu_dout = 8'h1B;
        n_iorq = 1'b0;
        n_wr = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        n_iorq = 1'b1;
        n_wr = 1'b1;
        push("rw_r7", 0, F_R7, 16'h00);
        push("rw_b_r7", 1, F_R7, 16'h00);
        push("rw_scr", 0, F_SCR, 16'd0);
        probe(16'hC000);

        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_left got=%0d exp=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_pager.md
Name: mem_pager

Overview:
- Parametrised memory banking unit for the Spectrum core; successor to the fixed 48K ROM/RAM decode.
- Captures CPU writes to paging ports 0x7FFD (128K) and, optionally, 0x1FFD (+2A/+3), and holds the lock bit.
- Translates each CPU address into a ROM/RAM bank plus 14-bit offset, and drives the shadow-screen select for the video fetcher.
- Sits between the CPU bus and the dual-port RAM; the 48K map is available as a parameter mode.

Parameters:
- MODE_128, 1: 0 = fixed 48K map with all port writes ignored; 1 = 128K paging.
- ENABLE_PLUS2A, 0: 1 = decode 0x1FFD, enable special all-RAM paging and the 2-bit ROM select.
- RAM_BANK_BITS, 3: width of the RAM bank number, range 3..5. Bits above 3 come from 0x7FFD[6] then [7].

Ports:
- clk  in  1  system clock; CPU-clock domain.
- reset  in  1  synchronous, active-high.
- cpu_addr  in  16  CPU address bus.
- cpu_dout  in  8  CPU data out.
- n_iorq, n_mreq, n_wr, n_m1  in  1 each  Z80 strobes, active-low.
- is_rom  out  1  current access targets ROM.
- rom_bank  out  2  ROM bank number; bit 1 is 0 unless ENABLE_PLUS2A.
- ram_bank  out  RAM_BANK_BITS  RAM bank for the current address.
- offset  out  14  cpu_addr[13:0].
- ram_we  out  1  ~n_mreq & ~n_wr & ~is_rom.
- screen_bank7  out  1  video fetches from bank 7 when set, otherwise bank 5.
- locked  out  1  paging lock state.
- reg_7ffd  out  8  paging register readback.
- reg_1ffd  out  8  +2A register readback; always 0 if !ENABLE_PLUS2A.

Behaviour:
- Reset (synchronous, one cycle): reg_7ffd=0x00, reg_1ffd=0x00, locked=0, internal write-edge flop=0.
  - Resulting outputs with cpu_addr=0x0000: is_rom=1, rom_bank=0, screen_bank7=0.
- IO write strobe: iow = ~n_iorq & ~n_wr & n_m1.
  - Flop iow_d each clk.
  - A write event is iow & ~iow_d, so exactly one event per OUT regardless of how long the strobe is held.
- Port decode, evaluated in the event cycle:
  - 7FFD hit: cpu_addr[15]=0 and cpu_addr[1]=0.
  - 1FFD hit: cpu_addr[15:12]=4'b0001 and cpu_addr[1]=0, only when ENABLE_PLUS2A.
  - 1FFD takes precedence over 7FFD.
- Register update:
  - On an event with locked=0: the addressed register loads cpu_dout at that clk edge. New mapping is visible in the next cycle (1-cycle latency).
  - locked is set when reg_7ffd[5] becomes 1. While locked=1, writes to both ports are ignored; only reset clears the lock.
  - MODE_128=0: registers never change.
- Address map, combinational from cpu_addr[15:14] and the registers:
  - MODE_128=0: seg0 = ROM0; seg1 = RAM5; seg2 = RAM2; seg3 = RAM0.
  - Normal 128K map:
    - seg0 = ROM, rom_bank = {ENABLE_PLUS2A ? reg_1ffd[2] : 0, reg_7ffd[4]}.
    - seg1 = RAM5; seg2 = RAM2.
    - seg3 = RAM {ext bits, reg_7ffd[2:0]}. Ext bits are reg_7ffd[6] when RAM_BANK_BITS≥4, and reg_7ffd[7] when RAM_BANK_BITS=5.
  - Special mode (ENABLE_PLUS2A and reg_1ffd[0]=1): all four segments are RAM, chosen by reg_1ffd[2:1]:
    - 0 → 0,1,2,3
    - 1 → 4,5,6,7
    - 2 → 4,5,6,3
    - 3 → 4,7,6,3
  - Fixed bank numbers are zero-extended to RAM_BANK_BITS.
- screen_bank7 = reg_7ffd[3] in 128K mode; 0 in 48K mode.
- ram_we is never asserted for ROM segments, so ROM writes are discarded.
- Reset asserted in the same cycle as a write event: reset wins and the registers take reset values.
- Outputs have no dependence on n_m1 apart from the strobe qualification.

Test Plan:
- Reset, then read 0x0000/0x4000/0x8000/0xC000 → is_rom=1 rom_bank=0; ram_bank=5; ram_bank=2; ram_bank=0. screen_bank7=0.
- OUT (0x7FFD),0x1B → next cycle: reg_7ffd=0x1B, 0xC000 gives ram_bank=3, rom_bank=1, screen_bank7=1.
  - Strobe held for 4 cycles → exactly one update.
- OUT (0x7FFD),0x24 sets locked=1, 0xC000 → bank 4. Then OUT (0x7FFD),0x07 → no change: bank stays 4, locked stays 1. Reset → locked=0, reg_7ffd=0x00.
- ENABLE_PLUS2A=1: OUT (0x1FFD),0x07 → seg0..3 = RAM 4,7,6,3 with is_rom=0. OUT (0x1FFD),0x04 then OUT (0x7FFD),0x10 → rom_bank=3.
- MODE_128=0: OUT (0x7FFD),0x07 → reg_7ffd stays 0x00 and the map is unchanged. Write to 0x1000 → ram_we=0.
- RAM_BANK_BITS=5: OUT (0x7FFD),0xC5 → 0xC000 gives ram_bank=5'b11101. Write with n_m1=0 (interrupt acknowledge) → ignored.
